// File: rtl/keypad_matrix_responder.sv
// 4x4 keypad-matrix responder: presses one key for a programmed number of column scans, then releases it.
// Define KPAD_BOUNCE_EN to add contact-bounce phases around each press (BOUNCE_IN before, BOUNCE_OUT after).
module keypad_matrix_responder #(
  parameter int GAP_SCANS      = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_code,
  input  logic [7:0] cmd_hold,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       pressed,
  output logic       done,
  output logic       timeout
);

  // Command handshake: a command transfers on a cycle where cmd_valid && cmd_ready;
  // cmd_ready is high only while idle, and valid without ready is dropped, never queued.

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = (GAP_SCANS > 0) ? 8'(GAP_SCANS - 1) : 8'd0;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_BOUNCE_IN  = 3'd1;
  localparam logic [2:0] S_PRESS      = 3'd2;
  localparam logic [2:0] S_BOUNCE_OUT = 3'd3;
  localparam logic [2:0] S_GAP        = 3'd4;

  logic [3:0]    sync_q [SYNC_STAGES];
  logic [3:0]    col_s;
  logic [3:0]    col_s_d;
  logic [2:0]    state, state_n;
  logic [3:0]    code_q, code_n;
  logic [7:0]    hold_q, hold_n;
  logic [7:0]    cnt_q, cnt_n;
  logic [TW-1:0] tcnt_q, tcnt_n;
  logic          vis_q, vis_n;
  logic          done_n, timeout_n;
  logic          scan_ev, expired;
  logic [3:0]    row_n;

  // Columns idle high, so the synchroniser resets to 4'hF to avoid a phantom falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'hF;
      col_s_d <= 4'hF;
    end else begin
      sync_q[0] <= col;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      col_s_d <= col_s;
    end
  end

  assign col_s   = sync_q[SYNC_STAGES-1];
  assign scan_ev = col_s_d[code_q[1:0]] & ~col_s[code_q[1:0]];
  assign expired = (tcnt_q == TIMEOUT_LAST);

  always_comb begin
    state_n   = state;
    code_n    = code_q;
    hold_n    = hold_q;
    cnt_n     = cnt_q;
    vis_n     = vis_q;
    done_n    = 1'b0;
    timeout_n = 1'b0;
    tcnt_n    = (state == S_IDLE || scan_ev) ? '0 : tcnt_q + TW'(1);

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          code_n = cmd_code;
          hold_n = (cmd_hold == 8'd0) ? 8'd1 : cmd_hold;
          cnt_n  = 8'd0;
          tcnt_n = '0;
          vis_n  = 1'b1;
`ifdef KPAD_BOUNCE_EN
          state_n = S_BOUNCE_IN;
`else
          state_n = S_PRESS;
`endif
        end
      end
`ifdef KPAD_BOUNCE_EN
      // Visible on odd events; the fourth (hidden) event hands over to PRESS.
      S_BOUNCE_IN: begin
        if (scan_ev) begin
          vis_n = ~cnt_q[0];
          if (cnt_q == 8'd3) begin
            state_n = S_PRESS;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = cnt_q + 8'd1;
          end
        end
      end
`endif
      // Event hold+1 hides the key in its own cycle so the scanner saw it exactly hold times.
      S_PRESS: begin
        if (scan_ev) begin
          if (cnt_q == hold_q) begin
            vis_n = 1'b0;
`ifdef KPAD_BOUNCE_EN
            state_n = S_BOUNCE_OUT;
            cnt_n   = 8'd1;
`else
            cnt_n = 8'd0;
            if (GAP_SCANS == 0) begin
              state_n = S_IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = S_GAP;
            end
`endif
          end else begin
            vis_n = 1'b1;
            cnt_n = cnt_q + 8'd1;
          end
        end
      end
`ifdef KPAD_BOUNCE_EN
      // The PRESS exit event counts as the first (hidden) release event.
      S_BOUNCE_OUT: begin
        if (scan_ev) begin
          vis_n = cnt_q[0];
          if (cnt_q == 8'd3) begin
            cnt_n = 8'd0;
            if (GAP_SCANS == 0) begin
              vis_n   = 1'b0;
              state_n = S_IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = S_GAP;
            end
          end else begin
            cnt_n = cnt_q + 8'd1;
          end
        end
      end
`endif
      S_GAP: begin
        if (scan_ev) begin
          vis_n = 1'b0;
          if (cnt_q == GAP_LAST) begin
            cnt_n   = 8'd0;
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        vis_n   = 1'b0;
        cnt_n   = 8'd0;
      end
    endcase

    // A scan event in the expiry cycle restarts the count instead of aborting.
    if (state != S_IDLE && !scan_ev && expired) begin
      vis_n     = 1'b0;
      cnt_n     = 8'd0;
      tcnt_n    = '0;
      state_n   = S_IDLE;
      done_n    = 1'b0;
      timeout_n = 1'b1;
    end

    row_n = 4'hF;
    if (vis_n && !col_s[code_n[1:0]]) row_n[code_n[3:2]] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      code_q    <= 4'd0;
      hold_q    <= 8'd0;
      cnt_q     <= 8'd0;
      tcnt_q    <= '0;
      vis_q     <= 1'b0;
      row       <= 4'hF;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      code_q    <= code_n;
      hold_q    <= hold_n;
      cnt_q     <= cnt_n;
      tcnt_q    <= tcnt_n;
      vis_q     <= vis_n;
      row       <= row_n;
      cmd_ready <= (state_n == S_IDLE);
      done      <= done_n;
      timeout   <= timeout_n;
    end
  end

  assign pressed = vis_q;

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Directed bench for keypad_matrix_responder: walks the scanner and checks per-scan key visibility.
module tb_keypad_matrix_responder;

  localparam int GAP = 4;

  logic       clk;
  logic       rst;
  logic       cmd_valid, cmd_ready, pressed, done, timeout;
  logic [3:0] cmd_code, col, row;
  logic [7:0] cmd_hold;
  logic       to_valid, to_ready, to_pressed, to_done, to_timeout;
  logic [3:0] to_code, to_col, to_row;
  logic [7:0] to_hold;

  int n_checks = 0;
  int n_errors = 0;

  keypad_matrix_responder dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_hold(cmd_hold), .col(col), .row(row),
    .pressed(pressed), .done(done), .timeout(timeout)
  );

  keypad_matrix_responder #(.TIMEOUT_CYCLES(64)) dut_to (
    .clk(clk), .rst(rst), .cmd_valid(to_valid), .cmd_ready(to_ready),
    .cmd_code(to_code), .cmd_hold(to_hold), .col(to_col), .row(to_row),
    .pressed(to_pressed), .done(to_done), .timeout(to_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit exp_vis(input int idx, input int h);
`ifdef KPAD_BOUNCE_EN
    if (idx < 4) return (idx % 2) == 0;
    idx -= 4;
    if (idx < h) return 1'b1;
    idx -= h;
    if (idx < 4) return (idx % 2) == 1;
    return 1'b0;
`else
    return idx < h;
`endif
  endfunction

  // Walks columns 0..3 (16 clk each); the target column is sampled once per scan mid-window.
  task automatic run_cmd(input string name, input logic [3:0] code, input logic [7:0] hold,
                         input bit issue, input int glitch_round, input bit chain,
                         input logic [3:0] next_code);
    int h, exp_done, done_seen, done_ev, to_seen, early_ready, bad_row;
    bit stop, pend, got;
    logic [3:0] exp_row;
    h = (hold == 8'd0) ? 1 : int'(hold);
`ifdef KPAD_BOUNCE_EN
    exp_done = h + 8 + GAP - 1;
`else
    exp_done = h + GAP;
`endif
    exp_row = 4'hF;
    exp_row[code[3:2]] = 1'b0;
    done_seen = 0; done_ev = -1; to_seen = 0; early_ready = 0; bad_row = 0;
    stop = 1'b0; pend = 1'b0;
    if (issue) begin
      col = 4'hF;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_code = code; cmd_hold = hold;
      @(negedge clk);
      if (!chain) cmd_valid = 1'b0;
      n_checks++;
      if (cmd_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL %s accept: cmd_ready=%b required 0", name, cmd_ready);
      end
    end
    for (int rd = 0; rd < exp_done + 2 && !stop; rd++) begin
      for (int ci = 0; ci < 4 && !stop; ci++) begin
        col = ~(4'b0001 << ci);
        for (int k = 0; k < 16 && !stop; k++) begin
          @(negedge clk);
          if (pend) begin
            cmd_valid = 1'b0;
            stop = 1'b1;
            n_checks++;
            if (cmd_ready !== 1'b0) begin
              n_errors++;
              $display("FAIL %s chained accept: cmd_ready=%b required 0", name, cmd_ready);
            end
          end else begin
            if (rd == glitch_round && ci == 0 && k == 0) begin
              cmd_valid = 1'b1; cmd_code = 4'hF;
            end else if (rd == glitch_round && ci == 0 && k == 1) begin
              cmd_valid = 1'b0; cmd_code = code;
            end
            if (done === 1'b1) begin
              done_seen++;
              done_ev = rd;
              if (chain) begin
                cmd_code = next_code;
                pend = 1'b1;
              end
            end
            if (timeout === 1'b1) to_seen++;
            if (done_seen == 0 && cmd_ready === 1'b1) early_ready++;
            if (k >= 4 && row !== 4'hF && !(ci == int'(code[1:0]) && row === exp_row)) bad_row++;
            if (k == 8 && ci == int'(code[1:0])) begin
              got = (row === exp_row);
              n_checks++;
              if (got !== exp_vis(rd, h) || pressed !== got) begin
                n_errors++;
                $display("FAIL %s scan %0d: row=%h pressed=%b required key_visible=%b", name, rd, row,
                         pressed, exp_vis(rd, h));
              end
            end
          end
        end
      end
    end
    n_checks++;
    if (done_seen != 1 || done_ev != exp_done) begin
      n_errors++;
      $display("FAIL %s done: pulses=%0d at scan %0d required 1 at scan %0d", name, done_seen, done_ev, exp_done);
    end
    n_checks++;
    if (to_seen != 0 || early_ready != 0 || bad_row != 0) begin
      n_errors++;
      $display("FAIL %s integrity: timeouts=%0d early_ready=%0d bad_rows=%0d required all 0", name,
               to_seen, early_ready, bad_row);
    end
    if (!chain) begin
      n_checks++;
      if (cmd_ready !== 1'b1 || pressed !== 1'b0 || row !== 4'hF) begin
        n_errors++;
        $display("FAIL %s idle after done: cmd_ready=%b pressed=%b row=%h required 1 0 f", name,
                 cmd_ready, pressed, row);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_code = 4'h0; cmd_hold = 8'd0; col = 4'hF;
    to_valid = 1'b0; to_code = 4'h0; to_hold = 8'd0; to_col = 4'hF;
    #13;
    n_checks++;
    if (row !== 4'hF || cmd_ready !== 1'b1 || pressed !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL reset values: row=%h ready=%b pressed=%b done=%b timeout=%b required f 1 0 0 0",
               row, cmd_ready, pressed, done, timeout);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (row !== 4'hF || cmd_ready !== 1'b1 || pressed !== 1'b0 || done !== 1'b0 ||
        to_row !== 4'hF || to_ready !== 1'b1 || to_timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL post-reset idle: row=%h ready=%b pressed=%b done=%b to_row=%h to_ready=%b required f 1 0 0 f 1",
               row, cmd_ready, pressed, done, to_row, to_ready);
    end
  endtask

  task automatic test_standard_press();
    run_cmd("standard", 4'h1, 8'd3, 1'b1, 1, 1'b0, 4'h0);
  endtask

  task automatic test_hold_zero();
    run_cmd("hold_zero", 4'h6, 8'd0, 1'b1, -1, 1'b0, 4'h0);
  endtask

  task automatic test_timeout();
    int t_at, bad, dn;
    t_at = -1; bad = 0; dn = 0;
    @(negedge clk);
    to_valid = 1'b1; to_code = 4'h1; to_hold = 8'd3;
    @(negedge clk);
    to_valid = 1'b0;
    n_checks++;
    if (to_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout accept: cmd_ready=%b required 0", to_ready);
    end
    for (int n = 1; n <= 200 && t_at < 0; n++) begin
      @(negedge clk);
      if (to_row !== 4'hF) bad++;
      if (to_done === 1'b1) dn++;
      if (to_timeout === 1'b1) t_at = n;
    end
    n_checks++;
    if (t_at != 64) begin
      n_errors++;
      $display("FAIL timeout latency: pulse after %0d cycles required 64", t_at);
    end
    n_checks++;
    if (bad != 0 || dn != 0 || to_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout side effects: bad_rows=%0d done=%0d ready=%b required 0 0 1", bad, dn, to_ready);
    end
    @(negedge clk);
    n_checks++;
    if (to_timeout !== 1'b0 || to_pressed !== 1'b0 || to_row !== 4'hF) begin
      n_errors++;
      $display("FAIL timeout aftermath: timeout=%b pressed=%b row=%h required 0 0 f", to_timeout, to_pressed, to_row);
    end
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_first", 4'h2, 8'd2, 1'b1, -1, 1'b1, 4'h3);
    run_cmd("b2b_second", 4'h3, 8'd2, 1'b0, -1, 1'b0, 4'h0);
  endtask

  task automatic test_reset_mid_press();
    bit found;
    int dn, bad;
    found = 1'b0; dn = 0; bad = 0;
    col = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = 4'h1; cmd_hold = 8'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int rd = 0; rd < 3 && !found; rd++) begin
      for (int ci = 0; ci < 4 && !found; ci++) begin
        col = ~(4'b0001 << ci);
        for (int k = 0; k < 16 && !found; k++) begin
          @(negedge clk);
          if (k == 8 && ci == 1 && row === 4'b1110) found = 1'b1;
        end
      end
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL reset_mid_press setup: row=%h required e within 3 scans", row);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (row !== 4'hF || cmd_ready !== 1'b1 || pressed !== 1'b0) begin
      n_errors++;
      $display("FAIL async reset: row=%h ready=%b pressed=%b required f 1 0", row, cmd_ready, pressed);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int rd = 0; rd < 2; rd++) begin
      for (int ci = 0; ci < 4; ci++) begin
        col = ~(4'b0001 << ci);
        for (int k = 0; k < 16; k++) begin
          @(negedge clk);
          if (done === 1'b1 || timeout === 1'b1) dn++;
          if (row !== 4'hF) bad++;
        end
      end
    end
    n_checks++;
    if (dn != 0 || bad != 0 || cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL after reset release: pulses=%0d bad_rows=%0d ready=%b required 0 0 1", dn, bad, cmd_ready);
    end
  endtask

`ifdef KPAD_BOUNCE_EN
  task automatic test_bounce();
    run_cmd("bounce", 4'h1, 8'd2, 1'b1, -1, 1'b0, 4'h0);
  endtask
`endif

  initial begin
    test_reset();
    test_standard_press();
    test_hold_zero();
    test_timeout();
    test_back_to_back();
`ifdef KPAD_BOUNCE_EN
    test_bounce();
`endif
    test_reset_mid_press();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
